// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared FSM encoding and default timing for the button conditioner
// Purpose: state constants, default parameter values and a held-state helper.
// Ports: none (package).
package button_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_CNT_W           = 19;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    // The key counts as held from acceptance until a release has been debounced.
    function automatic logic held_state(input logic [1:0] st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one key: 2-FF synchroniser, debounce FSM, press pulse
// Purpose: turns one raw bouncing key into a one-cycle press pulse and a debounced level.
// Optional feature: BUTTON_CONDITIONER_AUTO_REPEAT_EN adds hold-to-repeat pulses.
// Ports: clk, rst (sync active-high), i_raw (async key), o_press (registered pulse),
//        o_held (debounced level).
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_press,
    output logic o_held
);

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_chk_width
        $error("debounce_channel: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_repeat
        $error("debounce_channel: repeat timings must be positive");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_level;
    logic             w_cnt_done;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_rep_pulse;

    // Synchroniser resets to the released raw level so no false press follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_level    = r_sync2 ^ ACTIVE_LOW;
    assign w_cnt_done = (r_cnt == CNT_LAST);
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_level) begin
                        r_state <= ST_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_level) begin
                        r_state <= ST_IDLE;
                    end else if (w_cnt_done) begin
                        r_state <= ST_PRESSED;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (!w_level) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    // Key came back before the release settled: still the same press.
                    if (w_level) begin
                        r_state <= ST_PRESSED;
                    end else if (w_cnt_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX) + 1;

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_armed;
    logic             r_rep_pulse;
    logic             w_rep_last;

    // First interval is the initial hold delay; afterwards the shorter period.
    assign w_rep_last = r_rep_armed ? (r_rep_cnt == REP_W'(REPEAT_PERIOD - 1))
                                    : (r_rep_cnt == REP_W'(REPEAT_DELAY - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
            r_rep_pulse <= 1'b0;
        end else begin
            r_rep_pulse <= 1'b0;
            if (held_state(r_state)) begin
                if (w_rep_last) begin
                    r_rep_pulse <= 1'b1;
                    r_rep_cnt   <= '0;
                    r_rep_armed <= 1'b1;
                end else begin
                    r_rep_cnt <= r_rep_cnt + REP_W'(1);
                end
            end else begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b0;
            end
        end
    end

    assign w_rep_pulse = r_rep_pulse;
`else
    assign w_rep_pulse = 1'b0;
`endif

    assign o_press = r_press | w_rep_pulse;
    assign o_held  = held_state(r_state);

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two-key conditioner feeding the BCD up/down counter
// Purpose: debounces up/down keys and emits registered, mutually exclusive count strobes.
// Optional feature: BUTTON_CONDITIONER_AUTO_REPEAT_EN (hold-to-repeat, see debounce_channel).
// Ports: clk, rst (sync active-high), btn_up_raw, btn_down_raw (async keys),
//        count_up, count_down, en_count (one-cycle strobes), up_held, down_held (levels).
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic count_up,
    output logic count_down,
    output logic en_count,
    output logic up_held,
    output logic down_held
);

    localparam bit ACTIVE_LOW = (BTN_ACTIVE_LOW != 0);

    logic w_up_press;
    logic w_dn_press;
    logic w_up_held;
    logic w_dn_held;

    logic r_count_up;
    logic r_count_down;
    logic r_en_count;
    logic r_up_held;
    logic r_down_held;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .ACTIVE_LOW      (ACTIVE_LOW),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_up (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_up_raw),
        .o_press (w_up_press),
        .o_held  (w_up_held)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .ACTIVE_LOW      (ACTIVE_LOW),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_down (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_down_raw),
        .o_press (w_dn_press),
        .o_held  (w_dn_held)
    );

    // Coincident pulses are ambiguous for the counter, so both are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_up   <= 1'b0;
            r_count_down <= 1'b0;
            r_en_count   <= 1'b0;
            r_up_held    <= 1'b0;
            r_down_held  <= 1'b0;
        end else begin
            r_count_up   <= w_up_press & ~w_dn_press;
            r_count_down <= w_dn_press & ~w_up_press;
            r_en_count   <= w_up_press ^ w_dn_press;
            r_up_held    <= w_up_held;
            r_down_held  <= w_dn_held;
        end
    end

    assign count_up   = r_count_up;
    assign count_down = r_count_down;
    assign en_count   = r_en_count;
    assign up_held    = r_up_held;
    assign down_held  = r_down_held;

endmodule
